multi_modulus_divider: RTL and testbench
========================================

Name: multi_modulus_divider

Overview:
Parametrised programmable multi-modulus divider. It is the successor to the fixed dual-modulus 240/248 divider in the frac-N PLL feedback path. The divide ratio is reloadable every output period from the sigma-delta modulator through a valid/load handshake, so any integer ratio in [N_MIN, 2^CNT_W-1] is supported. The block sits between the VCO-side clock and the PFD feedback input.

Parameters:
CNT_W, 9, width of the ratio input and the down-counter.
N_DEFAULT, 248, ratio used after reset until a new ratio is consumed. Must satisfy N_MIN <= N_DEFAULT <= 2^CNT_W-1.
N_MIN, 8, smallest legal ratio. Smaller requests are clamped to this value.

Ports:
freq_in  input  1  divider clock (VCO-side); all logic on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
ratio_in  input  CNT_W  requested divide ratio N.
ratio_valid  input  1  ratio_in is valid this cycle.
freq_out  output  1  divided clock, registered.
div_load  output  1  one-cycle pulse: a ratio was consumed and a new period started.
cur_ratio  output  CNT_W  ratio of the period in progress.
ratio_err  output  1  sticky flag: an out-of-range ratio was clamped.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0 (terminal state); hold register = N_DEFAULT; cur_ratio = N_DEFAULT.
  - freq_out=0, div_load=0, ratio_err=0.
- Hold register: on any cycle with ratio_valid=1, it captures clamp(ratio_in). Last write wins.
- Terminal cycle (cnt==0), i.e. the reload edge:
  - next ratio R = clamp(ratio_in) if ratio_valid=1 this cycle (bypass), else the hold register.
  - cnt <= R-1; cur_ratio <= R; div_load <= 1; freq_out <= 1.
- Non-terminal cycle: cnt <= cnt-1; div_load <= 0.
- Duty: with k = cur_ratio-1-cnt (k=0..R-1), freq_out is registered high for k < H, where H is set by the optional feature below.
- Period: rising edges of freq_out are exactly R freq_in cycles apart. Ratio changes take effect only at period boundaries; there are never partial periods.
- First period: the first freq_out rising edge occurs on the first freq_in rising edge after reset deasserts, using N_DEFAULT unless ratio_valid is high on that edge.
- Clamp: ratio_in < N_MIN is replaced by N_MIN and sets ratio_err=1. ratio_err stays set until reset.
- Simultaneous ratio_valid and terminal cycle: the new value is used for the starting period and is also written to the hold register.
- Reset mid-period: the period aborts immediately and freq_out drops asynchronously to 0.
- Latency: ratio presented in period P (before its terminal cycle) governs period P+1. The div_load pulse coincides with the freq_out rising edge.

Optional Feature:
Macro DUTY50_EN.
- Defined: H = ceil(R/2), giving a near-50% duty cycle; odd R gives one extra high cycle.
- Undefined: H = 1, i.e. freq_out is a single-freq_in-cycle pulse per period. The duty comparator logic is removed.

Decomposition:
- Package freq_div_pkg holds:
  - CNT_W default and N_MIN default localparams;
  - a clamp function (ratio, nmin) -> ratio;
  - a high-time function (ratio) -> H, whose body is selected by DUTY50_EN.
- One sub-module, mmd_ratio_reg: hold register, clamp, bypass mux and sticky ratio_err. It outputs the next ratio to the counter core.

Test Plan:
1. 10 ns freq_in, reset released at 20 ns, ratio_valid=0 -> freq_out rising edges 2480 ns apart; cur_ratio=248; div_load pulses coincide with freq_out rising edges.
2. ratio_in=240 with a one-cycle ratio_valid mid-period -> current period stays 2480 ns, following periods are 2400 ns.
3. Alternate 240/248 on each div_load (ratio_valid held high) -> edge spacing sequence 2400, 2480, 2400, ... with no missed or extra edges.
4. ratio_in=3 valid -> next period is 80 ns (R=8); ratio_err=1 and stays 1 after a later legal ratio is applied, until reset.
5. reset pulled low mid-period at 1000 ns for 20 ns -> freq_out=0 immediately; first edge comes on the first clock after release, then 2480 ns periods resume.
6. DUTY50_EN defined, R=241 -> freq_out high 121 cycles, low 120. Undefined -> high 1 cycle, low 240.

Source files
------------

// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared constants and ratio helpers for the multi-modulus divider.
// Macro DUTY50_EN selects the high-time rule: near-50% duty when defined,
// single-cycle pulse otherwise.
package freq_div_pkg;

  localparam int CNT_W_DEF = 9;
  localparam int N_MIN_DEF = 8;

  // Requests below the legal minimum are raised to the minimum.
  function automatic int unsigned clamp_ratio(input int unsigned ratio,
                                              input int unsigned nmin);
    return (ratio < nmin) ? nmin : ratio;
  endfunction

  // Number of freq_in cycles that freq_out stays high in a period of length ratio.
  function automatic int unsigned high_time(input int unsigned ratio);
`ifdef DUTY50_EN
    return (ratio + 32'd1) >> 1;
`else
    // A clamped ratio is never zero, so this always yields a one-cycle pulse.
    return 32'(ratio != 32'd0);
`endif
  endfunction

endpackage

// File: rtl/mmd_ratio_reg.sv
// mmd_ratio_reg: ratio hold register with clamp, terminal-cycle bypass mux
// and sticky out-of-range flag. ratio_next is the ratio the counter core
// would load if this cycle were its reload edge.
module mmd_ratio_reg
  import freq_div_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int N_DEFAULT = 248,
  parameter int N_MIN     = N_MIN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] ratio_in,
  input  logic             ratio_valid,
  output logic [CNT_W-1:0] ratio_next,
  output logic             ratio_err
);

  logic [CNT_W-1:0] hold_reg;
  logic [CNT_W-1:0] ratio_clamped;
  logic             too_small;
  logic             err_reg;

  // Clamp the request and bypass the hold register when a fresh ratio arrives.
  always_comb begin
    ratio_clamped = CNT_W'(clamp_ratio(32'(ratio_in), 32'(N_MIN)));
    too_small     = (32'(ratio_in) < 32'(N_MIN));
    ratio_next    = ratio_valid ? ratio_clamped : hold_reg;
  end

  // Capture every valid request (last write wins); latch any clamp event until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= CNT_W'(N_DEFAULT);
      err_reg  <= 1'b0;
    end else if (ratio_valid) begin
      hold_reg <= ratio_clamped;
      if (too_small) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign ratio_err = err_reg;

endmodule

// File: rtl/multi_modulus_divider.sv
// multi_modulus_divider: programmable divide-by-R for the frac-N feedback path.
// A down-counter reloads with the next ratio whenever it reaches zero; the
// reload edge raises freq_out and pulses div_load. Macro DUTY50_EN widens the
// high time to ceil(R/2); without it freq_out is a one-cycle pulse.
module multi_modulus_divider
  import freq_div_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int N_DEFAULT = 248,
  parameter int N_MIN     = N_MIN_DEF
) (
  input  logic             freq_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] ratio_in,
  input  logic             ratio_valid,
  output logic             freq_out,
  output logic             div_load,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             ratio_err
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cur_ratio_reg, cur_ratio_next;
  logic [CNT_W-1:0] ratio_next;
  logic             freq_out_reg, freq_out_next;
  logic             div_load_reg, div_load_next;
  logic             terminal;
`ifdef DUTY50_EN
  logic [CNT_W-1:0] k_next;
  logic [CNT_W-1:0] high_cur;
`endif

  mmd_ratio_reg #(
    .CNT_W     (CNT_W),
    .N_DEFAULT (N_DEFAULT),
    .N_MIN     (N_MIN)
  ) u_ratio_reg (
    .clk         (freq_in),
    .rst_n       (reset),
    .ratio_in    (ratio_in),
    .ratio_valid (ratio_valid),
    .ratio_next  (ratio_next),
    .ratio_err   (ratio_err)
  );

  // Count down; at zero start a new period with the next ratio and raise freq_out.
  always_comb begin
    terminal       = (cnt_reg == '0);
    cnt_next       = cnt_reg - CNT_W'(1);
    cur_ratio_next = cur_ratio_reg;
    div_load_next  = 1'b0;
    freq_out_next  = 1'b0;
`ifdef DUTY50_EN
    // k_next is the position within the period that the next edge moves to.
    k_next   = cur_ratio_reg - cnt_reg;
    high_cur = CNT_W'(high_time(32'(cur_ratio_reg)));
`endif
    if (terminal) begin
      cnt_next       = ratio_next - CNT_W'(1);
      cur_ratio_next = ratio_next;
      div_load_next  = 1'b1;
      freq_out_next  = 1'b1;
    end else begin
`ifdef DUTY50_EN
      freq_out_next = (k_next < high_cur);
`endif
    end
  end

  // Period state; reset aborts the period and drops freq_out at once.
  always_ff @(posedge freq_in or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      cur_ratio_reg <= CNT_W'(N_DEFAULT);
      freq_out_reg  <= 1'b0;
      div_load_reg  <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      cur_ratio_reg <= cur_ratio_next;
      freq_out_reg  <= freq_out_next;
      div_load_reg  <= div_load_next;
    end
  end

  assign freq_out  = freq_out_reg;
  assign div_load  = div_load_reg;
  assign cur_ratio = cur_ratio_reg;

endmodule

// File: tb/tb_multi_modulus_divider.sv
// tb_multi_modulus_divider: directed, table-driven check of period length,
// high time, ratio latency, clamping, bypass/hold behaviour and reset abort.
`timescale 1ns/1ps
module tb_multi_modulus_divider;

  logic       freq_in;
  logic       reset;
  logic [8:0] ratio_in;
  logic       ratio_valid;
  logic       freq_out;
  logic       div_load;
  logic [8:0] cur_ratio;
  logic       ratio_err;

  int n_checks = 0;
  int n_fail   = 0;

  multi_modulus_divider #(
    .CNT_W     (9),
    .N_DEFAULT (248),
    .N_MIN     (8)
  ) dut (
    .freq_in     (freq_in),
    .reset       (reset),
    .ratio_in    (ratio_in),
    .ratio_valid (ratio_valid),
    .freq_out    (freq_out),
    .div_load    (div_load),
    .cur_ratio   (cur_ratio),
    .ratio_err   (ratio_err)
  );

  initial freq_in = 1'b0;
  always #5 freq_in = ~freq_in;

  typedef struct {
    logic [8:0] val;
    int         exp_r;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic int exp_high(input int r);
`ifdef DUTY50_EN
    return (r + 1) / 2;
`else
    return (r > 0) ? 1 : 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called right after a div_load sample; runs to the next div_load sample.
  // Optionally presents inj_val with a one-cycle ratio_valid when len==inj_at.
  task automatic run_period(input int inj_at, input logic [8:0] inj_val,
                            output int len, output int high);
    bit injected;
    injected = 1'b0;
    len  = 1;
    high = int'(freq_out);
    forever begin
      if (len == inj_at) begin
        ratio_in    = inj_val;
        ratio_valid = 1'b1;
        injected    = 1'b1;
      end
      @(posedge freq_in); #1;
      if (injected) begin
        ratio_valid = 1'b0;
        injected    = 1'b0;
      end
      if (div_load === 1'b1) break;
      len++;
      high += int'(freq_out);
      if (len > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL period_timeout: got no div_load within %0d cycles, required one", len);
        len = -1;
        break;
      end
    end
    check("load_with_rise", 32'(freq_out), 32'd1);
    $display("period ended at %0t: len=%0d high=%0d next cur_ratio=%0d err=%0b",
             $time, len, high, cur_ratio, ratio_err);
  endtask

  initial begin
    int len, high, prev_r, exp_len, nxt;

    vecs[0] = '{val: 9'd240, exp_r: 240, exp_err: 1'b0};
    vecs[1] = '{val: 9'd248, exp_r: 248, exp_err: 1'b0};
    vecs[2] = '{val: 9'd3,   exp_r: 8,   exp_err: 1'b1};
    vecs[3] = '{val: 9'd100, exp_r: 100, exp_err: 1'b1};
    vecs[4] = '{val: 9'd8,   exp_r: 8,   exp_err: 1'b1};
    vecs[5] = '{val: 9'd7,   exp_r: 8,   exp_err: 1'b1};
    vecs[6] = '{val: 9'd511, exp_r: 511, exp_err: 1'b1};
    vecs[7] = '{val: 9'd241, exp_r: 241, exp_err: 1'b1};

    reset       = 1'b0;
    ratio_in    = 9'd0;
    ratio_valid = 1'b0;

    // Reset state
    #12;
    check("rst_freq_out", 32'(freq_out), 32'd0);
    check("rst_div_load", 32'(div_load), 32'd0);
    check("rst_cur_ratio", 32'(cur_ratio), 32'd248);
    check("rst_ratio_err", 32'(ratio_err), 32'd0);
    #8 reset = 1'b1;

    // First edge after release uses N_DEFAULT
    @(posedge freq_in); #1;
    check("first_load", 32'(div_load), 32'd1);
    check("first_rise", 32'(freq_out), 32'd1);
    check("first_cur", 32'(cur_ratio), 32'd248);
    run_period(-1, 9'd0, len, high);
    check("default_len", 32'(len), 32'd248);
    check("default_high", 32'(high), 32'(exp_high(248)));

    // Table: ratio presented mid-period governs the following period
    prev_r = 248;
    for (int i = 0; i < 8; i++) begin
      run_period(3, vecs[i].val, len, high);
      check("vec_len", 32'(len), 32'(prev_r));
      check("vec_high", 32'(high), 32'(exp_high(prev_r)));
      check("vec_cur", 32'(cur_ratio), 32'(vecs[i].exp_r));
      check("vec_err", 32'(ratio_err), 32'(vecs[i].exp_err));
      prev_r = vecs[i].exp_r;
    end

    // Valid only on the terminal cycle: bypassed into the new period and held after
    run_period(prev_r, 9'd200, len, high);
    check("bypass_prev_len", 32'(len), 32'(prev_r));
    check("bypass_prev_high", 32'(high), 32'(exp_high(prev_r)));
    check("bypass_cur", 32'(cur_ratio), 32'd200);
    run_period(-1, 9'd0, len, high);
    check("bypass_len", 32'(len), 32'd200);
    run_period(-1, 9'd0, len, high);
    check("hold_len", 32'(len), 32'd200);
    check("hold_cur", 32'(cur_ratio), 32'd200);

    // Reset while freq_out is high: immediate drop, restart with defaults
    #2 reset = 1'b0;
    #1;
    check("abort_freq_out", 32'(freq_out), 32'd0);
    check("abort_div_load", 32'(div_load), 32'd0);
    check("abort_cur", 32'(cur_ratio), 32'd248);
    check("abort_err_clear", 32'(ratio_err), 32'd0);
    #19 reset = 1'b1;
    @(posedge freq_in); #1;
    check("restart_load", 32'(div_load), 32'd1);
    check("restart_rise", 32'(freq_out), 32'd1);
    check("restart_cur", 32'(cur_ratio), 32'd248);

    // Valid held high, ratio alternated at each period start
    exp_len     = 248;
    ratio_in    = 9'd240;
    ratio_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt = int'(ratio_in);
      run_period(-1, 9'd0, len, high);
      check("alt_len", 32'(len), 32'(exp_len));
      check("alt_cur", 32'(cur_ratio), 32'(nxt));
      exp_len  = nxt;
      ratio_in = (nxt == 240) ? 9'd248 : 9'd240;
    end
    ratio_valid = 1'b0;
    run_period(-1, 9'd0, len, high);
    check("alt_last_len", 32'(len), 32'(exp_len));
    check("alt_err", 32'(ratio_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
